// File: rtl/serial_mag_cmp_if.sv
// Operand request and compare-result bundle for serial_mag_cmp.
// Latency: none, wiring only.
// Backpressure: start is dropped unless busy is low.
interface serial_mag_cmp_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;

    modport master (
        output start, a, b, is_signed,
        input  busy, done, lt, eq, gt
    );

    modport slave (
        input  start, a, b, is_signed,
        output busy, done, lt, eq, gt
    );
endinterface

// File: rtl/serial_mag_cmp.sv
// Bit-serial MSB-first magnitude compare of two WIDTH-bit operands, signed or unsigned.
// Latency: WIDTH cycles, or WIDTH-k at the first differing bit k when EARLY_EXIT=1.
// Backpressure: start accepted only when idle; requests while busy are dropped.
module serial_mag_cmp #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_mag_cmp_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] MSB_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sgn_r;
    logic [CW-1:0]    cnt;
    logic             lt_n;
    logic             gt_n;
    logic             lt_r;
    logic             eq_r;
    logic             gt_r;

    logic             accept;
    logic             a_bit;
    logic             b_bit;
    logic             bit_lt;
    logic             bit_gt;
    logic             lt_acc;
    logic             gt_acc;
    logic             finish;

    assign accept = (state == IDLE) && bus.start;

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    always_comb begin
        a_bit = a_r[cnt];
        b_bit = b_r[cnt];
        if (sgn_r && (cnt == MSB_IDX)) begin
            a_bit = ~a_bit;
            b_bit = ~b_bit;
        end
    end

    always_comb begin
        bit_lt = ~a_bit & b_bit;
        bit_gt = a_bit & ~b_bit;
        // Only the first difference counts; a latched flag blocks the opposite one.
        lt_acc = lt_n | (~gt_n & bit_lt);
        gt_acc = gt_n | (~lt_n & bit_gt);
        finish = (cnt == '0) || (EARLY_EXIT && (bit_lt || bit_gt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (finish)    state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            sgn_r <= 1'b0;
            cnt   <= '0;
            lt_n  <= 1'b0;
            gt_n  <= 1'b0;
            lt_r  <= 1'b0;
            eq_r  <= 1'b0;
            gt_r  <= 1'b0;
        end else if (accept) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            sgn_r <= bus.is_signed;
            cnt   <= MSB_IDX;
            lt_n  <= 1'b0;
            gt_n  <= 1'b0;
            lt_r  <= 1'b0;
            eq_r  <= 1'b0;
            gt_r  <= 1'b0;
        end else if (state == RUN) begin
            if (finish) begin
                lt_r <= lt_acc;
                gt_r <= gt_acc;
                eq_r <= ~lt_acc & ~gt_acc;
            end else begin
                lt_n <= lt_acc;
                gt_n <= gt_acc;
                cnt  <= cnt - CW'(1);
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.lt   = lt_r;
    assign bus.eq   = eq_r;
    assign bus.gt   = gt_r;

    a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        bus.done |-> $onehot({bus.lt, bus.eq, bus.gt}));

    a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
        bus.done |=> !bus.done);

endmodule
